clock_bcd_counter: RTL and testbench
====================================

# clock_bcd_counter

Time-of-day counter for the 24-hour clock, producing hours, minutes and seconds as BCD digit pairs that feed the BCD-to-7-segment decoders directly. The block divides the system clock down to a 1 Hz tick, cascades BCD seconds, minutes and hours with correct wrap-around, and accepts two set buttons (hour, minute) for time adjustment. It also provides a colon-blink output and a one-cycle seconds pulse for the display scanner.

## Interface
- DIV, 32768: system clock cycles per second; prescaler counts 0..DIV-1; DIV >= 2, even.
- PW, 15: prescaler width; must satisfy 2^PW >= DIV.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn_hour  in  1  hour-set button, already debounced and synchronous to clk; level.
- btn_min  in  1  minute-set button, already debounced and synchronous to clk; level.
- hh_t  out  4  hours tens, BCD 0..2.
- hh_u  out  4  hours units, BCD 0..9 (0..3 when hh_t=2).
- mm_t  out  4  minutes tens, BCD 0..5.
- mm_u  out  4  minutes units, BCD 0..9.
- ss_t  out  4  seconds tens, BCD 0..5.
- ss_u  out  4  seconds units, BCD 0..9.
- colon  out  1  high while prescaler < DIV/2, low otherwise.
- sec_tick  out  1  registered one-cycle pulse, high in the cycle after a seconds increment.

## Operation
- Reset (rst=1 at an edge): all six digits 0 (00:00:00), prescaler 0, sec_tick 0, button-history registers 1. colon therefore 1. Reset dominates all other inputs.
- History regs reset to 1: a button held through reset does not register a press; it must be released and pressed again.
- Prescaler: increments each cycle; when at DIV-1 it wraps to 0 and the internal tick fires for that edge.
- Tick: seconds +1 in BCD. ss_u 9 -> 0 with ss_t +1; 59 -> 00 with carry to minutes. Minutes identical, 59 -> 00 with carry to hours. Hours: units 9 -> 0 with tens +1; 23 -> 00. No carry beyond hours. sec_tick <= 1 on that edge, otherwise 0.
- Button press = rising edge: btn high and history low at the same clk edge. History register samples the button every cycle.
- btn_min press: minutes +1 with wrap 59 -> 00, no carry into hours; seconds forced to 00; prescaler forced to 0; sec_tick stays 0 even if tick coincides.
- btn_hour press: hours +1 with wrap 23 -> 00; minutes and seconds unaffected.
- Simultaneous events, all within one edge:
- btn_min press with tick: minutes advance exactly once (the press), seconds 00, prescaler 0, no carry to hours from the tick.
- btn_hour press with a tick carry into hours (e.g. 23:59:59): hours advance exactly once (the press), so 23 -> 00; minutes and seconds roll to 00:00 normally.
- Both buttons pressed in the same cycle: both applied independently, per the rules above.
- Holding a button gives exactly one increment. No auto-repeat.
- Digits never leave the legal ranges listed. No other BCD values are reachable.

## Timing
- All outputs registered except colon, which is decoded combinationally from the prescaler register.
- Button latency: the digits update at the first rising edge where the press condition holds, and are visible in the following cycle.
- Tick period: exactly DIV cycles between consecutive sec_tick pulses when no btn_min press occurs.
- After a btn_min press at edge k, the next tick occurs at edge k+DIV.
- colon duty: DIV/2 cycles high, then DIV/2 low, per second; it restarts high on reset or on a btn_min press.

## Test plan
- Reset and free-run, DIV=4: after rst, outputs 00:00:00, colon=1. After 4 cycles, sec_tick pulses once and ss_u=1. After 240 cycles, time reads 00:01:00.
- Full rollover: preset to 23:59:59 via buttons and ticks, then one tick -> 00:00:00. Check hh_t/hh_u/mm/ss all 0 and sec_tick=1 for one cycle.
- btn_min wrap: at 10:59:37, press -> 10:00:00 (hours unchanged), prescaler 0. Hold for 20 cycles -> no further increment.
- btn_hour wrap: at 23:15:20, press -> 00:15:20. Press 10 more times -> 10:15:20, passing 09 -> 10 correctly.
- Coincidence: at 23:59:59, btn_hour press on the tick edge -> 00:00:00 (one hour increment only). At 12:34:59, btn_min press on the tick edge -> 12:35:00 with sec_tick=0.
- Reset mid-operation: with btn_min held, assert rst for 1 cycle at 07:42:13 -> 00:00:00. Keep btn_min held: no increment. Release and press: -> 00:01:00.

Source files
------------

// File: rtl/clock_bcd_counter.sv
// ============================================================================
//  Module      : clock_bcd_counter
//  Description : 24-hour BCD time-of-day counter with a 1 Hz prescaler,
//                hour/minute set buttons, colon blink and a seconds pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_bcd_counter #(
    parameter int DIV = 32768,
    parameter int PW  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_hour,
    input  logic       btn_min,
    output logic [3:0] hh_t,
    output logic [3:0] hh_u,
    output logic [3:0] mm_t,
    output logic [3:0] mm_u,
    output logic [3:0] ss_t,
    output logic [3:0] ss_u,
    output logic       colon,
    output logic       sec_tick
);

    localparam logic [PW-1:0] C_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] C_HALF = PW'(DIV / 2);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hh_t_q, hh_t_d, hh_u_q, hh_u_d;
    logic [3:0]    mm_t_q, mm_t_d, mm_u_q, mm_u_d;
    logic [3:0]    ss_t_q, ss_t_d, ss_u_q, ss_u_d;
    logic          sec_tick_q, sec_tick_d;
    logic          hist_hour_q, hist_min_q;

    logic w_tick, w_min_press, w_hour_press, w_sec_carry, w_min_carry;

    function automatic logic [7:0] inc_base60(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            return (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hours(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) begin
            return 8'h00;
        end
        if (u == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    always_comb begin
        w_tick       = (presc_q == C_LAST);
        w_min_press  = btn_min  & ~hist_min_q;
        w_hour_press = btn_hour & ~hist_hour_q;
        w_sec_carry  = w_tick & (ss_t_q == 4'd5) & (ss_u_q == 4'd9);
        // A minute press replaces the tick, so no seconds carry may reach minutes or hours.
        w_min_carry  = w_sec_carry & ~w_min_press & (mm_t_q == 4'd5) & (mm_u_q == 4'd9);

        presc_d    = (w_tick | w_min_press) ? '0 : presc_q + 1'b1;
        sec_tick_d = w_tick & ~w_min_press;

        {ss_t_d, ss_u_d} = {ss_t_q, ss_u_q};
        {mm_t_d, mm_u_d} = {mm_t_q, mm_u_q};
        {hh_t_d, hh_u_d} = {hh_t_q, hh_u_q};

        if (w_min_press) begin
            {ss_t_d, ss_u_d} = 8'h00;
            {mm_t_d, mm_u_d} = inc_base60(mm_t_q, mm_u_q);
        end else if (w_tick) begin
            {ss_t_d, ss_u_d} = inc_base60(ss_t_q, ss_u_q);
            if (w_sec_carry) begin
                {mm_t_d, mm_u_d} = inc_base60(mm_t_q, mm_u_q);
            end
        end

        // The hour press and a carry into hours merge into a single increment.
        if (w_hour_press | w_min_carry) begin
            {hh_t_d, hh_u_d} = inc_hours(hh_t_q, hh_u_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            hh_t_q      <= 4'd0;
            hh_u_q      <= 4'd0;
            mm_t_q      <= 4'd0;
            mm_u_q      <= 4'd0;
            ss_t_q      <= 4'd0;
            ss_u_q      <= 4'd0;
            sec_tick_q  <= 1'b0;
            hist_hour_q <= 1'b1;
            hist_min_q  <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            hh_t_q      <= hh_t_d;
            hh_u_q      <= hh_u_d;
            mm_t_q      <= mm_t_d;
            mm_u_q      <= mm_u_d;
            ss_t_q      <= ss_t_d;
            ss_u_q      <= ss_u_d;
            sec_tick_q  <= sec_tick_d;
            hist_hour_q <= btn_hour;
            hist_min_q  <= btn_min;
        end
    end

    assign hh_t     = hh_t_q;
    assign hh_u     = hh_u_q;
    assign mm_t     = mm_t_q;
    assign mm_u     = mm_u_q;
    assign ss_t     = ss_t_q;
    assign ss_u     = ss_u_q;
    assign sec_tick = sec_tick_q;
    assign colon    = (presc_q < C_HALF);

endmodule

`default_nettype wire

// File: tb/tb_clock_bcd_counter.sv
// ============================================================================
//  Module      : tb_clock_bcd_counter
//  Description : Scoreboard bench for clock_bcd_counter with a seconds-of-day
//                reference model, directed scenarios and random button traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_bcd_counter;

    localparam int DIV = 4;
    localparam int PW  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_hour = 1'b0;
    logic       btn_min  = 1'b0;
    logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
    logic       colon, sec_tick;

    clock_bcd_counter #(.DIV(DIV), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_hour (btn_hour),
        .btn_min  (btn_min),
        .hh_t     (hh_t),
        .hh_u     (hh_u),
        .mm_t     (mm_t),
        .mm_u     (mm_u),
        .ss_t     (ss_t),
        .ss_u     (ss_u),
        .colon    (colon),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ht, hu, mt, mu, st, su;
        logic       colon;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time as seconds of day, prescaler as a plain count.
    int m_tod   = 0;
    int m_presc = 0;
    bit m_hh    = 1'b1;
    bit m_hm    = 1'b1;

    task automatic model(input bit r, input bit bh, input bit bm);
        int   h, m, s, hn, mn, sn, t2;
        bit   tk, mp, hp, st;
        exp_t e;
        if (r) begin
            m_tod = 0; m_presc = 0; m_hh = 1'b1; m_hm = 1'b1; st = 1'b0;
        end else begin
            tk = (m_presc == DIV - 1);
            mp = bm && !m_hm;
            hp = bh && !m_hh;
            h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
            hn = h; mn = m; sn = s;
            if (mp) begin
                mn = (m + 1) % 60;
                sn = 0;
            end else if (tk) begin
                t2 = (m_tod + 1) % 86400;
                hn = t2 / 3600; mn = (t2 / 60) % 60; sn = t2 % 60;
            end
            if (hp) hn = (h + 1) % 24;
            m_presc = (tk || mp) ? 0 : m_presc + 1;
            st      = tk && !mp;
            m_hh    = bh;
            m_hm    = bm;
            m_tod   = hn * 3600 + mn * 60 + sn;
        end
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        e.ht = 4'(h / 10); e.hu = 4'(h % 10);
        e.mt = 4'(m / 10); e.mu = 4'(m % 10);
        e.st = 4'(s / 10); e.su = 4'(s % 10);
        e.colon = (m_presc < DIV / 2);
        e.tick  = st;
        q.push_back(e);
    endtask

    task automatic step(input bit r, input bit bh, input bit bm);
        @(negedge clk);
        rst = r; btn_hour = bh; btn_min = bm;
        model(r, bh, bm);
    endtask

    task automatic press_hour();
        step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    endtask

    task automatic press_min();
        step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    endtask

    task automatic to_tick_edge();
        for (int i = 0; i < 2 * DIV && m_presc != DIV - 1; i++) step(0, 0, 0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        for (int i = 0; i < 30 && (m_tod / 3600) != h; i++) press_hour();
        for (int i = 0; i < 70 && ((m_tod / 60) % 60) != m; i++) press_min();
        for (int i = 0; i < 400 && (m_tod % 60) != s; i++) step(0, 0, 0);
    endtask

    // Monitor: every cycle the registered outputs are one scoreboard response.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, colon, sec_tick};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got %h%h:%h%h:%h%h colon=%b tick=%b, exp %h%h:%h%h:%h%h colon=%b tick=%b",
                             $time, got.ht, got.hu, got.mt, got.mu, got.st, got.su, got.colon, got.tick,
                             e.ht, e.hu, e.mt, e.mu, e.st, e.su, e.colon, e.tick);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and free-run one minute.
        step(1, 0, 0); step(1, 0, 0);
        for (int i = 0; i < 240; i++) step(0, 0, 0);

        // Full rollover on a tick.
        set_time(23, 59, 59);
        to_tick_edge();
        step(0, 0, 0); step(0, 0, 0);

        // Minute wrap without hour carry, then hold.
        set_time(10, 59, 37);
        press_min();
        for (int i = 0; i < 20; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Hour wrap and eleven presses through 09 -> 10.
        set_time(23, 15, 20);
        for (int i = 0; i < 11; i++) press_hour();

        // Hour press coinciding with a full carry.
        set_time(23, 59, 59);
        to_tick_edge();
        step(0, 1, 0); step(0, 0, 0);

        // Minute press coinciding with a seconds tick.
        set_time(12, 34, 59);
        to_tick_edge();
        step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);

        // Both buttons together.
        step(0, 1, 1); step(0, 0, 0);

        // Reset while btn_min is held, then release and press.
        set_time(7, 41, 0);
        for (int i = 0; i < 52; i++) step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 0);

        // Random traffic with occasional reset.
        begin
            bit bh, bm, r;
            bh = 0; bm = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) bh = ~bh;
                if ($urandom_range(7) == 0) bm = ~bm;
                r = ($urandom_range(199) == 0);
                step(r, bh, bm);
            end
        end

        step(0, 0, 0);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
